// File: rtl/mmio_uart_tx_if.sv
// Bus-side signal bundle for the memory-mapped UART transmitter.
// The CPU/bus side drives the master modport; the peripheral uses the slave modport.
interface mmio_uart_tx_if;
    logic        select;
    logic        write_enable;
    logic [15:0] address;
    logic [15:0] write_data;
    logic [15:0] read_data;
    logic        hit;

    modport master (
        output select, write_enable, address, write_data,
        input  read_data, hit
    );

    modport slave (
        input  select, write_enable, address, write_data,
        output read_data, hit
    );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: a data register pushes bytes into a FIFO,
// a status register reports FIFO and FSM state, and an FSM serialises bytes on tx.
module mmio_uart_tx #(
    parameter logic [15:0] BASE_ADDRESS = 16'hFFF4,
    parameter int          CLKS_PER_BIT = 868,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic          clock,
    input  logic          reset,
    mmio_uart_tx_if.slave bus,
    output logic          tx,
    output logic          busy
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;
    logic [15:0]     read_data_q, read_data_d;

    logic [7:0]      mem [FIFO_DEPTH];

    logic            full, empty, pop, push, wr_req;
    logic            addr_data, addr_stat;
    logic            baud_done;
    logic [15:0]     status;
    logic            unused_write_data;

    assign unused_write_data = ^bus.write_data[15:8];

    assign addr_data = (bus.address == BASE_ADDRESS);
    assign addr_stat = (bus.address == BASE_ADDRESS + 16'd1);
    assign bus.hit   = bus.select & (addr_data | addr_stat);

    assign full      = (count_q == COUNT_FULL);
    assign empty     = (count_q == '0);
    assign baud_done = (baud_q == BAUD_LAST);

    // A pop frees a slot on the same edge, so a write to a full FIFO still lands.
    assign pop    = (state_q == IDLE) & ~empty;
    assign wr_req = bus.select & bus.write_enable & addr_data;
    assign push   = wr_req & (~full | pop);

    assign busy   = (state_q != IDLE) | ~empty;
    // With FIFO_DEPTH=256 the count field wraps to 0 when full; the full bit disambiguates.
    assign status = {8'(count_q), 4'b0000, overflow_q, busy, empty, full};

    always_comb begin
        // NOTE: every _d gets a default first so no path can infer a latch.
        state_d     = state_q;
        baud_d      = baud_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        read_data_d = read_data_q;

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (wr_req && !push) overflow_d = 1'b1;

        if (bus.select && !bus.write_enable) begin
            if (addr_stat)      read_data_d = status;
            else if (addr_data) read_data_d = 16'h0000;
        end

        case (state_q)
            IDLE: begin
                if (pop) begin
                    shift_d = mem[rd_ptr_q];
                    baud_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                baud_d = baud_done ? '0 : baud_q + 1'b1;
                if (baud_done) begin
                    bit_idx_d = 3'd0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                baud_d = baud_done ? '0 : baud_q + 1'b1;
                if (baud_done) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                baud_d = baud_done ? '0 : baud_q + 1'b1;
                if (baud_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // tx follows the current state one edge later, keeping the line registered.
        case (state_q)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_q[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            baud_q      <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            tx_q        <= 1'b1;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            read_data_q <= '0;
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            read_data_q <= read_data_d;
        end
    end

    // NOTE: FIFO storage has no reset; entries are only read after being written.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr_q] <= bus.write_data[7:0];
    end

    assign tx            = tx_q;
    assign bus.read_data = read_data_q;
endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the NBBPU data bus, in parallel with the data RAM.
- Decodes a small register window near the top of the address space. Buffers bytes written by the CPU in a FIFO and serialises them as 8N1 on a single TX line.
- Exposes a status register so firmware can poll for space and idle before writing.

Parameters:
BASE_ADDRESS, 16'hFFF4, address of TX data register; status register at BASE_ADDRESS+1
CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); minimum 2
FIFO_DEPTH, 8, FIFO entries; power of two, 2..256

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
select  input  1  bus select from NBBPU side
write_enable  input  1  bus write strobe
address  input  16  bus address
write_data  input  16  bus write data; only [7:0] used
read_data  output  16  registered read data for status register
hit  output  1  combinational: select & address in {BASE_ADDRESS, BASE_ADDRESS+1}; used by bus read mux
tx  output  1  UART serial output, idle high
busy  output  1  high while FSM not IDLE or FIFO not empty

Behaviour:
- Reset values, asynchronous assert and held while reset is high:
  - tx=1, read_data=0, busy=0.
  - FIFO pointers and count = 0.
  - FSM=IDLE, bit counter=0, baud counter=0.
- Reset mid-frame aborts the frame; tx returns to 1 immediately.
- Write to BASE_ADDRESS (select & write_enable & address match) pushes write_data[7:0] on that rising edge if FIFO not full.
  - A write when full is dropped silently.
  - Sets sticky overflow flag, cleared only by reset.
- Write to BASE_ADDRESS+1 is ignored.
- Read of BASE_ADDRESS+1 (select & !write_enable): read_data valid on the next rising edge (1-cycle latency, same as RAM).
  - Status layout:
    - [0] full
    - [1] empty
    - [2] busy
    - [3] overflow
    - [15:8] count (zero-extended)
  - Other bits 0.
- Reading BASE_ADDRESS returns 0.
- read_data holds its value when not reading.
- FIFO:
  - Circular buffer, write/read pointers wrap modulo FIFO_DEPTH.
  - count ranges 0..FIFO_DEPTH.
  - full = (count==FIFO_DEPTH), empty = (count==0).
  - Simultaneous push and pop in one cycle: both occur and count is unchanged.
  - When full, a simultaneous pop and push both occur; no overflow flag is set.
- FSM states:
  - IDLE:
    - tx=1.
    - If FIFO not empty: pop head into shift register, go to START, baud counter=0.
  - START:
    - tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA:
    - tx=shift[0] for CLKS_PER_BIT cycles each, LSB first.
    - Shift right after each bit.
    - After bit 7, go to STOP.
  - STOP:
    - tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Frame length = 10*CLKS_PER_BIT cycles, measured from the first cycle tx=0.
- Back-to-back bytes: IDLE lasts exactly one cycle between frames when FIFO is non-empty.
- Latency from a push into an empty FIFO with FSM idle to tx falling: 2 clock edges. Pop occurs on the edge after the push; tx goes low on the following edge.
- tx is a registered output, glitch-free.
- busy = (state!=IDLE) | !empty.
- Addresses outside the window:
  - hit=0.
  - No state change.

Test Plan:
- Assert reset for 20 ns mid-clock → tx=1, busy=0, and status read returns 16'h0002 on the next edge. Release reset → no tx activity for 1000 cycles.
- CLKS_PER_BIT=4, write 16'hAB55 to FFF4 → tx=0 for 4 cycles, then data bits 1,0,1,0,1,0,1,0 at 4 cycles each, then tx=1 for 4 cycles. busy falls after 40+2 cycles.
- Write 3 bytes 8'h01, 8'h02, 8'h03 back-to-back → three frames, each separated by exactly one IDLE cycle. Status count reads 2, 1, 0 as frames start.
- FIFO_DEPTH=8, 10 consecutive writes with FSM busy:
  - status shows full=1 and overflow=1;
  - first 9 bytes are transmitted (one popped immediately plus 8 buffered);
  - 10th byte is lost.
- Push while full on the same cycle the FSM pops → count stays 8 and overflow stays 0.
- Assert reset during the DATA state → tx goes high asynchronously and FIFO empties. A subsequent write transmits a clean frame.
